psum_accum: RTL and testbench
=============================

Name: psum_accum

Overview:
- Downstream consumer of the corelet output FIFO.
- Drains column-parallel partial sums from the OFIFO over nkij kernel-position passes and accumulates them per output pixel in an internal buffer.
- After the final pass, streams ReLU-activated results to the output memory writer through a valid/ready handshake.
- Replaces the bare sfp_col path for the output-stationary accumulation flow.

Parameters:
- psum_bw, 16, width of one signed partial sum.
- col, 8, number of array columns (psums per OFIFO word).
- npix, 16, output pixels per kernel-position pass (OFIFO words per pass).
- nkij, 9, kernel positions (passes) accumulated per job.
- aw, 4, width of the pixel index; must satisfy 2^aw >= npix.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  job start pulse; honoured only in IDLE.
- busy  output  1  high in DRAIN or OUT.
- done  output  1  one-cycle pulse after the last output handshake.
- ofifo_out  input  col*psum_bw  head word of the OFIFO (show-ahead); column c occupies bits [c*psum_bw +: psum_bw].
- ofifo_o_valid  input  1  OFIFO head word valid.
- ofifo_rd  output  1  pop OFIFO; the word is consumed in any cycle where ofifo_rd=1.
- out_data  output  col*psum_bw  ReLU result for pixel out_addr.
- out_addr  output  aw  pixel index of out_data.
- out_valid  output  1  out_data/out_addr valid.
- out_ready  input  1  downstream accepts; handshake = out_valid & out_ready.

Behaviour:
- Decided: one clock (clk); reset is asynchronous and active-high (reset).

Reset:
- state=IDLE; pix=0; kij=0; oidx=0.
- busy=0, done=0, ofifo_rd=0, out_valid=0, out_data=0, out_addr=0.
- Buffer contents are don't-care; no clearing is required because pass 0 overwrites every entry.

FSM, IDLE:
- start=1 -> DRAIN; pix=0, kij=0.
- start=0 -> remain in IDLE.

FSM, DRAIN:
- ofifo_rd = ofifo_o_valid (combinational). It is never asserted outside DRAIN.
- On each pop, per column c: buf[pix][c] = (kij==0) ? in_c : buf[pix][c] + in_c.
- The addition is signed, two's complement, psum_bw wide, and wraps modulo 2^psum_bw with no saturation.
- pix increments after each pop. When pix==npix-1 it wraps to 0 and kij increments.
- The pop with kij==nkij-1 and pix==npix-1 moves the FSM to OUT with oidx=0, in the next cycle.
- An OFIFO bubble (ofifo_o_valid=0) stalls the counters with no other effect.

FSM, OUT:
- out_valid=1, out_addr=oidx.
- out_data column c = buf[oidx][c] if its sign bit is 0, else 0 (ReLU).
- Outputs are held stable while out_ready=0.
- On each handshake oidx increments.
- On the handshake with oidx==npix-1: go to IDLE, out_valid drops, and done=1 for exactly the next cycle.
- The OFIFO is not read during OUT.

Latency:
- First out_valid appears 1 cycle after the final pop.
- Minimum job length is npix*nkij + npix cycles plus 1 cycle for start.

Boundary conditions:
- start while busy is ignored, and counters are unaffected.
- start in the same cycle as done is accepted, because the FSM is already in IDLE.
- Assertion of reset mid-job aborts immediately to the reset state. A partial OFIFO drain is not recovered; the upstream is flushed by the same reset.
- npix=1 and nkij=1 are legal. The single pop goes straight to OUT.

Test Plan:
1. Reset with start=0, then 3 idle cycles -> all outputs 0, ofifo_rd=0, busy=0.
2. npix=16, nkij=9, every column of every word = 16'h0001, ofifo_o_valid held high, out_ready=1 -> exactly 144 pops; then 16 outputs with out_addr 0..15, each column = 9; done pulses once; busy=1 for 160 cycles.
3. Mixed signs for pixel 3, col 0: nine pops of -5 -> output 0 (ReLU). Pixel 3, col 1: values +7 and then eight of -1 -> output -1 wrapped before ReLU? No: 7-8 = -1, so the output is 0. Pixel 4, col 0: 16'h7FFF followed by 16'h0001 and then zeros -> wraps to 16'h8000, so the output is 0.
4. ofifo_o_valid toggles 1,0,1,0 and out_ready is randomly low 50% of cycles -> results identical to scenario 2, no pop while valid=0, out_data/out_addr stable while out_ready=0.
5. reset asserted after 50 pops, then a fresh start with all-2 data -> outputs all 18, proving no carry-over from the aborted job.
6. start pulsed during DRAIN and during OUT -> ignored; start on the done cycle -> new job starts and ofifo_rd asserts the following cycle.

Source files
------------

// File: rtl/psum_accum.sv
// ---------------------------------------------------------------------------
// psum_accum
//
// Output-stationary partial-sum accumulator sitting behind the corelet OFIFO.
// A job drains nkij passes of npix column-parallel OFIFO words. Each word is
// accumulated into a per-pixel buffer entry. The first pass overwrites the
// entry and later passes add to it. After the final pass the buffer is
// streamed out through a ReLU, one pixel per handshake.
//
// Handshakes:
//   OFIFO side : show-ahead. The head word on ofifo_out is consumed in any
//                cycle where ofifo_rd=1. ofifo_rd simply mirrors
//                ofifo_o_valid while draining and is 0 otherwise.
//   Output side: valid/ready. A beat transfers on out_valid & out_ready.
//                While out_ready=0, out_valid/out_addr/out_data are held.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   start         in   job start pulse, only honoured in IDLE
//   busy          out  high while draining or outputting
//   done          out  one-cycle pulse after the last output handshake
//   ofifo_out     in   OFIFO head word, column c at [c*psum_bw +: psum_bw]
//   ofifo_o_valid in   OFIFO head word valid
//   ofifo_rd      out  OFIFO pop
//   out_data      out  ReLU result for pixel out_addr (0 when not valid)
//   out_addr      out  pixel index of out_data (0 when not valid)
//   out_valid     out  out_data/out_addr valid
//   out_ready     in   downstream accepts
//   dbg_state     out  current FSM state (IDLE=0, DRAIN=1, OUT=2)
// ---------------------------------------------------------------------------
module psum_accum #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int npix    = 16,
    parameter int nkij    = 9,
    parameter int aw      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    input  logic                     ofifo_o_valid,
    output logic                     ofifo_rd,
    output logic [col*psum_bw-1:0]   out_data,
    output logic [aw-1:0]            out_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               dbg_state
);

    localparam int W  = col * psum_bw;
    // Keep the pass counter at least one bit wide so nkij=1 is legal.
    localparam int KW = (nkij > 1) ? $clog2(nkij) : 1;

    localparam logic [aw-1:0] PIX_LAST = aw'(npix - 1);
    localparam logic [KW-1:0] KIJ_LAST = KW'(nkij - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [aw-1:0]   pix_q, pix_d;
    logic [KW-1:0]   kij_q, kij_d;
    logic [aw-1:0]   oidx_q, oidx_d;
    logic            done_q, done_d;

    logic            pop;
    logic [W-1:0]    acc_word;
    logic [W-1:0]    mem_rd_word;
    logic [W-1:0]    out_word;

    // Accumulation buffer. It is never reset because pass 0 writes every
    // entry before any entry is read.
    logic [W-1:0]    psum_mem_q [npix];

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            kij_q   <= '0;
            oidx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            kij_q   <= kij_d;
            oidx_q  <= oidx_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        kij_d     = kij_q;
        oidx_d    = oidx_q;
        done_d    = 1'b0;
        ofifo_rd  = 1'b0;
        out_valid = 1'b0;
        pop       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRAIN;
                    pix_d   = '0;
                    kij_d   = '0;
                end
            end

            S_DRAIN: begin
                // A bubble leaves every counter untouched.
                ofifo_rd = ofifo_o_valid;
                pop      = ofifo_o_valid;
                if (ofifo_o_valid) begin
                    if (pix_q == PIX_LAST) begin
                        pix_d = '0;
                        if (kij_q == KIJ_LAST) begin
                            kij_d   = '0;
                            oidx_d  = '0;
                            state_d = S_OUT;
                        end else begin
                            kij_d = kij_q + 1'b1;
                        end
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end
            end

            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (oidx_q == PIX_LAST) begin
                        oidx_d  = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        oidx_d = oidx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulation datapath
    // ------------------------------------------------------------------
    assign mem_rd_word = psum_mem_q[pix_q];

    // Plain modular addition: two's-complement wrap needs no sign handling.
    always_comb begin
        acc_word = '0;
        for (int c = 0; c < col; c++) begin
            if (kij_q == '0) begin
                acc_word[c*psum_bw +: psum_bw] = ofifo_out[c*psum_bw +: psum_bw];
            end else begin
                acc_word[c*psum_bw +: psum_bw] = mem_rd_word[c*psum_bw +: psum_bw]
                                               + ofifo_out[c*psum_bw +: psum_bw];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            psum_mem_q[pix_q] <= acc_word;
        end
    end

    // ------------------------------------------------------------------
    // ReLU output path. Data and address are forced to 0 outside OUT so
    // the output bus is quiet while idle or draining.
    // ------------------------------------------------------------------
    assign out_word = psum_mem_q[oidx_q];

    always_comb begin
        out_data = '0;
        for (int c = 0; c < col; c++) begin
            if ((state_q == S_OUT) && !out_word[c*psum_bw + psum_bw - 1]) begin
                out_data[c*psum_bw +: psum_bw] = out_word[c*psum_bw +: psum_bw];
            end
        end
    end

    assign out_addr  = (state_q == S_OUT) ? oidx_q : '0;
    assign busy      = (state_q == S_DRAIN) || (state_q == S_OUT);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_psum_accum.sv
// ---------------------------------------------------------------------------
// tb_psum_accum
//
// Directed sequence of jobs driven from one initial block. The OFIFO is a
// show-ahead queue of words. Expected outputs come either from literal
// constants (uniform data) or from a reference model that sums each
// pixel/column over all passes with integer arithmetic, wraps to psum_bw
// bits and applies ReLU. Expected results are kept in exp_q in output order.
// ---------------------------------------------------------------------------
module tb_psum_accum;

    localparam int PBW   = 16;
    localparam int COL   = 8;
    localparam int NPIX  = 16;
    localparam int NKIJ  = 9;
    localparam int AW    = 4;
    localparam int W     = PBW * COL;
    localparam int TOTAL = NPIX * NKIJ;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic [W-1:0]    ofifo_out;
    logic            ofifo_o_valid;
    logic            ofifo_rd;
    logic [W-1:0]    out_data;
    logic [AW-1:0]   out_addr;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      dbg_state;

    always #5 clk = ~clk;

    psum_accum #(
        .psum_bw (PBW),
        .col     (COL),
        .npix    (NPIX),
        .nkij    (NKIJ),
        .aw      (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .ofifo_out     (ofifo_out),
        .ofifo_o_valid (ofifo_o_valid),
        .ofifo_rd      (ofifo_rd),
        .out_data      (out_data),
        .out_addr      (out_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .dbg_state     (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] gen_w [TOTAL];
    int           n_chk = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: per pixel/column sum over passes, wrap, ReLU.
    // Word index for pass k, pixel p is k*NPIX + p.
    // ------------------------------------------------------------------
    task automatic model_push();
        logic [W-1:0]          word_exp;
        logic signed [PBW-1:0] sv;
        logic [PBW-1:0]        r;
        int                    acc;
        for (int p = 0; p < NPIX; p++) begin
            word_exp = '0;
            for (int c = 0; c < COL; c++) begin
                acc = 0;
                for (int k = 0; k < NKIJ; k++) begin
                    sv  = gen_w[k*NPIX + p][c*PBW +: PBW];
                    acc = acc + sv;
                end
                r = acc[PBW-1:0];
                if (!r[PBW-1]) word_exp[c*PBW +: PBW] = r;
            end
            exp_q.push_back(word_exp);
        end
    endtask

    // kind 0: all ones, kind 1: all twos, kind 2: mixed signs, kind 3: random
    task automatic load_job(input int kind);
        logic [W-1:0] cw;
        for (int i = 0; i < TOTAL; i++) begin
            for (int c = 0; c < COL; c++) begin
                case (kind)
                    0:       gen_w[i][c*PBW +: PBW] = 16'h0001;
                    1:       gen_w[i][c*PBW +: PBW] = 16'h0002;
                    default: gen_w[i][c*PBW +: PBW] = 16'($urandom_range(0, 65535));
                endcase
            end
        end
        if (kind == 2) begin
            for (int k = 0; k < NKIJ; k++) begin
                gen_w[k*NPIX + 3][0*PBW +: PBW] = -16'sd5;
                gen_w[k*NPIX + 3][1*PBW +: PBW] = (k == 0) ? 16'sd7 : -16'sd1;
                gen_w[k*NPIX + 4][0*PBW +: PBW] = (k == 0) ? 16'h7FFF :
                                                  (k == 1) ? 16'h0001 : 16'h0000;
            end
        end
        for (int i = 0; i < TOTAL; i++) fifo_q.push_back(gen_w[i]);
        if (kind == 0 || kind == 1) begin
            for (int c = 0; c < COL; c++) cw[c*PBW +: PBW] = (kind == 0) ? 16'd9 : 16'd18;
            for (int p = 0; p < NPIX; p++) exp_q.push_back(cw);
        end else begin
            model_push();
        end
    endtask

    // ------------------------------------------------------------------
    // Driver + per-cycle checker for one job.
    //   do_start : pulse start in cycle 0 (else the job was started by the
    //              previous job's done cycle)
    //   vtoggle  : OFIFO valid only on even cycles
    //   rrand    : out_ready random 50%
    //   poke     : random start pulses while busy
    //   chain    : drive start in the done cycle
    //   abort_at : leave once this many pops are seen (0 = never)
    // ------------------------------------------------------------------
    task automatic run_job(input bit do_start, input bit vtoggle, input bit rrand,
                           input bit poke, input bit chain, input int abort_at,
                           output int pops, output int busy_cnt);
        int           cyc;
        int           n_out;
        bit           fin;
        bit           v;
        bit           in_drain;
        bit           exp_ov;
        logic [W-1:0] exp_w;
        pops     = 0;
        n_out    = 0;
        busy_cnt = 0;
        cyc      = 0;
        fin      = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (do_start && cyc == 0)  start = 1'b1;
            else if (n_out == NPIX)    start = chain;
            else                       start = poke && ($urandom_range(0, 3) == 0);
            v             = (fifo_q.size() > 0) && (!vtoggle || (cyc % 2 == 0));
            ofifo_o_valid = v;
            ofifo_out     = v ? fifo_q[0] : {$urandom, $urandom, $urandom, $urandom};
            out_ready     = rrand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            in_drain = (!do_start || cyc > 0) && (pops < TOTAL);
            exp_ov   = (pops == TOTAL) && (n_out < NPIX);
            chk("ofifo_rd", W'(ofifo_rd), W'(v && in_drain));
            chk("out_valid", W'(out_valid), W'(exp_ov));
            chk("busy", W'(busy), W'(in_drain || exp_ov));
            chk("done", W'(done), W'(n_out == NPIX));
            if (busy) busy_cnt++;
            if (exp_ov) begin
                exp_w = (exp_q.size() > 0) ? exp_q[0] : 'x;
                chk("out_addr", W'(out_addr), W'(n_out));
                chk("out_data", out_data, exp_w);
            end
            if (ofifo_rd && v) begin
                void'(fifo_q.pop_front());
                pops++;
            end
            if (n_out == NPIX) begin
                fin = 1'b1;
            end else if (exp_ov && out_valid && out_ready) begin
                void'(exp_q.pop_front());
                n_out++;
            end
            if (abort_at > 0 && pops == abort_at) fin = 1'b1;
            cyc++;
            if (!fin && cyc > 4000) begin
                chk("job_timeout", W'(cyc), W'(0));
                fin = 1'b1;
            end
        end
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_busy"},      W'(busy),      W'(0));
        chk({tag, "_done"},      W'(done),      W'(0));
        chk({tag, "_ofifo_rd"},  W'(ofifo_rd),  W'(0));
        chk({tag, "_out_valid"}, W'(out_valid), W'(0));
        chk({tag, "_out_addr"},  W'(out_addr),  W'(0));
        chk({tag, "_out_data"},  out_data,      W'(0));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int pops;
        int bc;
        reset         = 1'b1;
        start         = 1'b0;
        ofifo_o_valid = 1'b0;
        ofifo_out     = '0;
        out_ready     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        idle_checks("in_reset");
        reset = 1'b0;

        // Idle after reset, with a valid OFIFO word presented and no start.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ofifo_o_valid = 1'b1;
            ofifo_out     = {$urandom, $urandom, $urandom, $urandom};
            out_ready     = 1'b1;
            #1;
            idle_checks("idle");
        end

        // All-ones job, no bubbles, always ready.
        load_job(0);
        run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, pops, bc);
        chk("ones_pops", W'(pops), W'(TOTAL));
        chk("ones_busy_cycles", W'(bc), W'(TOTAL + NPIX));

        // Mixed signs and wrap-around.
        load_job(2);
        run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, pops, bc);

        // All-ones with OFIFO bubbles and random back-pressure.
        load_job(0);
        run_job(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, pops, bc);
        chk("bubble_pops", W'(pops), W'(TOTAL));

        // Abort after 50 pops, then a clean all-twos job.
        load_job(3);
        run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 50, pops, bc);
        chk("abort_pops", W'(pops), W'(50));
        fifo_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset         = 1'b1;
        ofifo_o_valid = 1'b1;
        #1;
        idle_checks("abort_reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        idle_checks("after_abort");
        load_job(1);
        run_job(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, pops, bc);
        chk("twos_pops", W'(pops), W'(TOTAL));

        // Start pokes while busy, then a job chained on the done cycle.
        // The second job's words sit in the OFIFO during the first job's OUT.
        load_job(3);
        load_job(3);
        run_job(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, pops, bc);
        chk("poke_pops", W'(pops), W'(TOTAL));
        run_job(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, pops, bc);
        chk("chain_pops", W'(pops), W'(TOTAL));

        // Random data with bubbles, back-pressure and start pokes.
        load_job(3);
        run_job(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, pops, bc);
        chk("rand_pops", W'(pops), W'(TOTAL));

        @(negedge clk);
        start = 1'b0;
        #1;
        idle_checks("final");
        chk("final_exp_q_empty", W'(exp_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
